// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - capture multiplexed 7-segment digits into debounced frames
module seg7_capture #(
  parameter int DIGITS               = 2,
  parameter int STABLE               = 4,
  parameter bit COMMON_ANODE_CATHODE = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DIGITS-1:0]     i_dig_en,
  input  logic [6:0]            i_seg,
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_err,
  output logic [DIGITS-1:0]     o_blank
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  // per-digit sampling state
  logic [6:0]          last_q [DIGITS];
  logic [6:0]          last_d [DIGITS];
  logic [7:0]          cnt_q  [DIGITS];
  logic [7:0]          cnt_d  [DIGITS];
  logic [4*DIGITS-1:0] digit_q, digit_d;
  logic [DIGITS-1:0]   dblank_q, dblank_d;
  logic [DIGITS-1:0]   cap_q, cap_d;

  // output slot
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   oblank_q, oblank_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic [6:0] lit;
  logic [3:0] nib;
  logic       pat_ok;
  logic       pat_blank;
  logic       multi_hot;
  logic       slot_free;

  assign lit       = COMMON_ANODE_CATHODE ? i_seg : ~i_seg;
  assign multi_hot = (i_dig_en & (i_dig_en - DIGITS'(1))) != '0;
  assign slot_free = !valid_q || i_ready;

  // decode the lit-high segment pattern into a hex nibble
  always_comb begin
    nib       = 4'h0;
    pat_ok    = 1'b1;
    pat_blank = 1'b0;
    case (lit)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      7'h00: pat_blank = 1'b1;
      default: pat_ok = 1'b0;
    endcase
  end

  // debounce/accept the selected digit, then hand complete frames to the output slot
  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    dblank_d = dblank_q;
    cap_d    = cap_q;
    value_d  = value_q;
    oblank_d = oblank_q;
    valid_d  = valid_q;
    err_d    = 1'b0;

    if (multi_hot) begin
      // ambiguous select: throw away all progress but keep stored digits
      for (int k = 0; k < DIGITS; k++) begin
        cnt_d[k] = 8'd0;
      end
      cap_d = '0;
      err_d = 1'b1;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (i_dig_en[k]) begin
          if (lit == last_q[k]) begin
            if (cnt_q[k] != STABLE_C) begin
              cnt_d[k] = cnt_q[k] + 8'd1;
              // accept only on the transition into saturation
              if (cnt_q[k] == STABLE_C - 8'd1) begin
                if (pat_ok) begin
                  digit_d[4*k +: 4] = nib;
                  dblank_d[k]       = pat_blank;
                  cap_d[k]          = 1'b1;
                end else begin
                  cap_d[k] = 1'b0;
                  err_d    = 1'b1;
                end
              end
            end
          end else begin
            last_d[k] = lit;
            cnt_d[k]  = 8'd1;
            cap_d[k]  = 1'b0;
          end
        end
      end
    end

    // next-state captured bits are used so the frame loads on the final sample edge
    if ((&cap_d) && slot_free) begin
      value_d  = digit_d;
      oblank_d = dblank_d;
      valid_d  = 1'b1;
      cap_d    = '0;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        last_q[k] <= 7'd0;
        cnt_q[k]  <= 8'd0;
      end
      digit_q  <= '0;
      dblank_q <= '0;
      cap_q    <= '0;
      value_q  <= '0;
      oblank_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        last_q[k] <= last_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      digit_q  <= digit_d;
      dblank_q <= dblank_d;
      cap_q    <= cap_d;
      value_q  <= value_d;
      oblank_q <= oblank_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign o_value = value_q;
  assign o_blank = oblank_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter DIGITS, default 2, number of multiplexed digits captured per frame (1..8).
REQ-002 Parameter STABLE, default 4, consecutive identical samples required to accept a digit (2..255).
REQ-003 Parameter COMMON_ANODE_CATHODE, default 0: 0 = common anode, segment lit when low; 1 = common cathode, segment lit when high.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  synchronous, active-low reset.
REQ-006 i_dig_en  input  DIGITS  digit select, active high; bit k selects digit k.
REQ-007 i_seg  input  7  segment lines {g,f,e,d,c,b,a}, bit 0 = a.
REQ-008 o_value  output  4*DIGITS  decoded frame; nibble k = digit k.
REQ-009 o_valid  output  1  o_value holds an unconsumed frame.
REQ-010 i_ready  input  1  consumer accepts o_value when high with o_valid.
REQ-011 o_err  output  1  one-cycle pulse on an invalid accepted pattern or a multi-hot i_dig_en.
REQ-012 o_blank  output  DIGITS  bit k set when digit k of the current o_value was blank.

Function
REQ-013 Segment lines shall be normalised to lit-high: lit = i_seg when COMMON_ANODE_CATHODE=1, else ~i_seg.
REQ-014 Lit patterns {g..a} map to nibbles: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F; 00 = blank, decoded as 0; all others invalid.
REQ-015 A cycle with i_dig_en all zero shall leave all internal state unchanged.
REQ-016 A cycle with more than one i_dig_en bit set shall clear all per-digit counters and captured flags, keep stored digits unchanged, and pulse o_err.
REQ-017 Each digit k shall own a last-pattern register and a saturating sample counter (0..STABLE).
REQ-018 On a one-hot cycle selecting k: if lit equals last-pattern[k], counter[k] increments, saturating at STABLE; otherwise last-pattern[k] = lit and counter[k] = 1.
REQ-019 On the cycle counter[k] transitions to STABLE, the digit is accepted: if valid, digit[k] and blank[k] are stored and captured[k] set; if invalid, captured[k] is cleared and o_err pulses the following cycle.
REQ-020 Further identical samples after saturation shall not re-accept or re-pulse o_err.
REQ-021 A changed pattern after acceptance shall clear captured[k] until the new pattern is accepted.
REQ-022 When all captured bits are set and the output slot is free (o_valid low, or o_valid and i_ready high this cycle), o_value/o_blank load from the stored digits, o_valid is high next cycle, and all captured bits clear.
REQ-023 Latency: o_valid rises one cycle after the cycle presenting the final digit's STABLE-th identical sample.
REQ-024 While o_valid high and i_ready low, o_value and o_blank shall hold stable; o_valid deasserts only after a cycle with i_ready high.
REQ-025 If a frame completes while the slot is occupied and i_ready is low, captured bits stay set and the load occurs on the first cycle the slot frees; no frame is dropped or overwritten.
REQ-026 Simultaneous frame completion and i_ready high shall load the new frame with o_valid remaining high (back-to-back).

Reset
REQ-027 While i_rst_n is low at a clock edge: o_value=0, o_valid=0, o_err=0, o_blank=0, all counters, last-pattern registers, stored digits and captured flags cleared.
REQ-028 Reset asserted mid-frame or with o_valid high shall discard the partial or pending frame; capture restarts from empty on the first edge with i_rst_n high.

Verification (DIGITS=2, STABLE=4, COMMON_ANODE_CATHODE=0)
REQ-029 i_ready=1; digit0 i_seg=0x40 (lit 3F) x4 cycles, then digit1 i_seg=0x24 x4 -> o_valid one cycle after last sample, o_value=0x20, o_blank=00, no o_err.
REQ-030 Digit0 i_seg=0x7F x4 (blank), digit1 i_seg=0x0E x4 -> o_value=0xF0, o_blank=01.
REQ-031 Digit0 i_seg=0x55 (invalid) x4 -> single o_err pulse, no frame; follow with 0x79 x4 on digit0 and 0x79 x4 on digit1 -> o_value=0x11.
REQ-032 i_dig_en=11 for one cycle mid-capture -> o_err pulse, counters reset, frame requires full re-capture of both digits.
REQ-033 i_ready=0 with frame 0x20 pending, second frame 0x35 completes -> o_value holds 0x20; raise i_ready one cycle -> next cycle o_value=0x35, o_valid stays high.
REQ-034 Assert i_rst_n=0 for one cycle after digit0 accepted -> all outputs 0; digit1 alone x4 produces no frame.
